// File: rtl/pflash_pkg.sv
// pflash_pkg: shared state encodings, timer width and half-word select
// constants for pflash_wb_ctrl. The write-cycle states exist only when
// PFLASH_WRITE_EN is defined.
package pflash_pkg;

  // Wide enough for the longest phase (the reset hold).
  localparam int TMR_W = 16;

  // Byte-select patterns for the two legal 16-bit command writes (big-endian).
  localparam logic [3:0] SEL_HI_HALF = 4'b1100;
  localparam logic [3:0] SEL_LO_HALF = 4'b0011;

  // Flash word offset of each WB half-word: high half at +0, low half at +1.
  localparam logic HALF_HI_OFS = 1'b0;
  localparam logic HALF_LO_OFS = 1'b1;

  typedef enum logic [3:0] {
    ST_RESET    = 4'd0,
    ST_IDLE     = 4'd1,
    ST_RD_LO    = 4'd2,
    ST_RD_GAP   = 4'd3,
    ST_RD_HI    = 4'd4,
`ifdef PFLASH_WRITE_EN
    ST_WR_SETUP = 4'd5,
    ST_WR_PULSE = 4'd6,
    ST_WR_HOLD  = 4'd7,
`endif
    ST_ACK      = 4'd8,
    ST_ERR      = 4'd9
  } state_t;

  function automatic logic wr_sel_ok(input logic [3:0] sel);
    return (sel == SEL_HI_HALF) || (sel == SEL_LO_HALF);
  endfunction

endpackage

// File: rtl/pflash_wb_ctrl_timer.sv
// pflash_cycle_timer: loadable down-counter with zero flag. One instance is
// shared by the reset hold, the read phases and the write pulse.
module pflash_cycle_timer #(
  parameter int           W       = 16,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  // Load takes priority; otherwise count down and park at zero.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)               r_cnt <= RST_VAL;
    else if (i_load)         r_cnt <= i_val;
    else if (r_cnt != '0)    r_cnt <= r_cnt - W'(1);
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/pflash_wb_ctrl.sv
// pflash_wb_ctrl: Wishbone classic slave driving a 16-bit async NOR flash.
// A 32-bit read becomes two timed 16-bit reads (high half first); writes are
// single 16-bit command cycles. Define PFLASH_WRITE_EN to build the write
// path; without it every WB write is answered with wb_err_o.
module pflash_wb_ctrl
  import pflash_pkg::*;
#(
  parameter int FLASH_AW = 23,
  parameter int RST_CYC  = 64,
  parameter int RD_CYC   = 6,
  parameter int WR_CYC   = 4
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic [FLASH_AW:0]   wb_adr_i,
  input  logic [31:0]         wb_dat_i,
  input  logic [3:0]          wb_sel_i,
  input  logic                wb_we_i,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  output logic [31:0]         wb_dat_o,
  output logic                wb_ack_o,
  output logic                wb_err_o,
  output logic [FLASH_AW-1:0] flash_adr_o,
  input  logic [15:0]         flash_dq_i,
  output logic [15:0]         flash_dq_o,
  output logic                flash_dq_oe_o,
  output logic                flash_ce_n_o,
  output logic                flash_oe_n_o,
  output logic                flash_we_n_o,
  output logic                flash_adv_n_o,
  output logic                flash_rst_n_o,
  output logic                flash_clk_o
);

  localparam logic [TMR_W-1:0] RST_LD = TMR_W'(RST_CYC - 1);
  localparam logic [TMR_W-1:0] RD_LD  = TMR_W'(RD_CYC - 1);

  state_t                r_state, w_state_nxt;
  logic                  w_tmr_load, w_tmr_zero;
  logic [TMR_W-1:0]      w_tmr_val;
  logic                  w_req, w_busy, w_unused;
  logic [FLASH_AW-1:0]   r_adr;
  logic [31:0]           r_dat;
  logic                  r_abort;

  assign w_req       = wb_cyc_i & wb_stb_i;
  assign flash_clk_o = 1'b0;
  assign flash_adr_o = r_adr;
  assign wb_dat_o    = r_dat;

`ifdef PFLASH_WRITE_EN
  localparam logic [TMR_W-1:0] WR_LD = TMR_W'(WR_CYC - 1);
  logic [15:0] r_dq;

  assign flash_dq_o = r_dq;
  assign w_busy     = (r_state == ST_RD_LO) || (r_state == ST_RD_GAP) || (r_state == ST_RD_HI) ||
                      (r_state == ST_WR_SETUP) || (r_state == ST_WR_PULSE) || (r_state == ST_WR_HOLD);
  assign w_unused   = ^wb_adr_i[1:0];

  // Latch the command half-word when a legal write is accepted.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)
      r_dq <= '0;
    else if (r_state == ST_IDLE && w_req && wb_we_i)
      r_dq <= (wb_sel_i == SEL_HI_HALF) ? wb_dat_i[31:16] : wb_dat_i[15:0];
  end
`else
  assign flash_dq_o = '0;
  assign w_busy     = (r_state == ST_RD_LO) || (r_state == ST_RD_GAP) || (r_state == ST_RD_HI);
  assign w_unused   = ^{wb_adr_i[1:0], wb_dat_i, wb_sel_i};
`endif

  pflash_cycle_timer #(
    .W       (TMR_W),
    .RST_VAL (RST_LD)
  ) u_timer (
    .i_clk  (wb_clk_i),
    .i_rst  (wb_rst_i),
    .i_load (w_tmr_load),
    .i_val  (w_tmr_val),
    .o_zero (w_tmr_zero)
  );

  // State register; reset restarts the flash reset hold.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) r_state <= ST_RESET;
    else          r_state <= w_state_nxt;
  end

  // Next state, timer control and Moore-decoded strobes.
  always_comb begin
    w_state_nxt   = r_state;
    w_tmr_load    = 1'b0;
    w_tmr_val     = RD_LD;
    flash_ce_n_o  = 1'b1;
    flash_oe_n_o  = 1'b1;
    flash_we_n_o  = 1'b1;
    flash_adv_n_o = 1'b1;
    flash_dq_oe_o = 1'b0;
    flash_rst_n_o = 1'b1;
    wb_ack_o      = 1'b0;
    wb_err_o      = 1'b0;
    case (r_state)
      ST_RESET: begin
        flash_rst_n_o = 1'b0;
        if (w_tmr_zero) w_state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (w_req) begin
          if (!wb_we_i) begin
            w_state_nxt = ST_RD_LO;
            w_tmr_load  = 1'b1;
          end
`ifdef PFLASH_WRITE_EN
          else if (wr_sel_ok(wb_sel_i)) w_state_nxt = ST_WR_SETUP;
`endif
          else w_state_nxt = ST_ERR;
        end
      end
      ST_RD_LO: begin
        flash_ce_n_o  = 1'b0;
        flash_oe_n_o  = 1'b0;
        flash_adv_n_o = 1'b0;
        if (w_tmr_zero) w_state_nxt = ST_RD_GAP;
      end
      ST_RD_GAP: begin
        w_state_nxt = ST_RD_HI;
        w_tmr_load  = 1'b1;
      end
      ST_RD_HI: begin
        flash_ce_n_o  = 1'b0;
        flash_oe_n_o  = 1'b0;
        flash_adv_n_o = 1'b0;
        if (w_tmr_zero) w_state_nxt = ST_ACK;
      end
`ifdef PFLASH_WRITE_EN
      ST_WR_SETUP: begin
        flash_ce_n_o  = 1'b0;
        flash_adv_n_o = 1'b0;
        flash_dq_oe_o = 1'b1;
        w_state_nxt   = ST_WR_PULSE;
        w_tmr_load    = 1'b1;
        w_tmr_val     = WR_LD;
      end
      ST_WR_PULSE: begin
        flash_ce_n_o  = 1'b0;
        flash_adv_n_o = 1'b0;
        flash_we_n_o  = 1'b0;
        flash_dq_oe_o = 1'b1;
        if (w_tmr_zero) w_state_nxt = ST_WR_HOLD;
      end
      ST_WR_HOLD: begin
        flash_ce_n_o  = 1'b0;
        flash_adv_n_o = 1'b0;
        flash_dq_oe_o = 1'b1;
        w_state_nxt   = ST_ACK;
      end
`endif
      ST_ACK: begin
        // An abandoned cycle still finishes on the flash side but is not acked.
        wb_ack_o    = ~r_abort;
        w_state_nxt = ST_IDLE;
      end
      ST_ERR: begin
        wb_err_o    = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Flash address, read-data capture and abandoned-cycle tracking.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_adr   <= '0;
      r_dat   <= '0;
      r_abort <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && w_req) begin
        r_abort <= 1'b0;
        r_adr   <= {wb_adr_i[FLASH_AW:2],
                    (wb_we_i && wb_sel_i == SEL_LO_HALF) ? HALF_LO_OFS : HALF_HI_OFS};
      end
      if (w_busy && !wb_cyc_i)
        r_abort <= 1'b1;
      if (r_state == ST_RD_LO && w_tmr_zero)
        r_dat[31:16] <= flash_dq_i;
      if (r_state == ST_RD_GAP)
        r_adr[0] <= HALF_LO_OFS;
      if (r_state == ST_RD_HI && w_tmr_zero)
        r_dat[15:0] <= flash_dq_i;
    end
  end

endmodule

// File: tb/tb_pflash_wb_ctrl.sv
// Self-checking bench for pflash_wb_ctrl: transaction-level reference model,
// per-cycle output compare, directed literal checks and random traffic.
// Honours PFLASH_WRITE_EN the same way as the design.
`timescale 1ns/1ps
module tb_pflash_wb_ctrl;

  localparam int FLASH_AW = 23;
  localparam int RST_CYC  = 64;
  localparam int RD_CYC   = 6;
  localparam int WR_CYC   = 4;
`ifdef PFLASH_WRITE_EN
  localparam bit WR_EN = 1'b1;
`else
  localparam bit WR_EN = 1'b0;
`endif
  localparam int K_RD = 0, K_WR = 1, K_ERR = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [FLASH_AW:0]   wb_adr = '0;
  logic [31:0]         wb_dat = '0;
  logic [3:0]          wb_sel = '0;
  logic                wb_we = 1'b0, wb_cyc = 1'b0, wb_stb = 1'b0;
  logic [31:0]         wb_dat_o;
  logic                wb_ack, wb_err;
  logic [FLASH_AW-1:0] f_adr;
  logic [15:0]         f_dq_i, f_dq_o;
  logic                f_dq_oe, f_ce_n, f_oe_n, f_we_n, f_adv_n, f_rst_n, f_clk;

  logic [15:0] mem [0:4095];
  int n_checks = 0, n_errors = 0;
  int cyc_n = 0, rel_cyc = 0, rise_cyc = -1, we_low_cnt = 0;
  logic [FLASH_AW-1:0] pulse_adr = '0;
  logic [15:0]         pulse_dq = '0;

  always #5 clk = ~clk;

  pflash_wb_ctrl #(.FLASH_AW(FLASH_AW), .RST_CYC(RST_CYC), .RD_CYC(RD_CYC), .WR_CYC(WR_CYC)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(wb_adr), .wb_dat_i(wb_dat), .wb_sel_i(wb_sel),
    .wb_we_i(wb_we), .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_dat_o(wb_dat_o),
    .wb_ack_o(wb_ack), .wb_err_o(wb_err), .flash_adr_o(f_adr), .flash_dq_i(f_dq_i),
    .flash_dq_o(f_dq_o), .flash_dq_oe_o(f_dq_oe), .flash_ce_n_o(f_ce_n), .flash_oe_n_o(f_oe_n),
    .flash_we_n_o(f_we_n), .flash_adv_n_o(f_adv_n), .flash_rst_n_o(f_rst_n), .flash_clk_o(f_clk)
  );

  // Flash part: drives its array only while selected and output-enabled.
  assign f_dq_i = (!f_ce_n && !f_oe_n) ? mem[f_adr[11:0]] : 16'h0000;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Observers used by the directed checks.
  always @(negedge clk) begin
    if (!rst && f_rst_n && rise_cyc < 0) rise_cyc = cyc_n - rel_cyc;
    if (!f_we_n) begin
      we_low_cnt = we_low_cnt + 1;
      pulse_adr  = f_adr;
      pulse_dq   = f_dq_o;
    end
  end

  // Reference model: one transaction at a time, described by its kind and the
  // cycle index k within it (k=0 is the cycle after the request is taken).
  int          m_rst_left = RST_CYC, m_k = 0, m_len = 0, m_kind = 0;
  bit          m_busy = 1'b0, m_abort = 1'b0, m_wlo = 1'b0;
  logic [21:0] m_base = '0;
  logic [15:0] m_wdat = '0;
  logic [31:0] m_rdat = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rst_left <= RST_CYC;
      m_busy     <= 1'b0;
      m_abort    <= 1'b0;
    end else if (m_rst_left > 0) begin
      m_rst_left <= m_rst_left - 1;
    end else if (m_busy) begin
      if (m_k < m_len - 1 && !wb_cyc) m_abort <= 1'b1;
      m_k <= m_k + 1;
      if (m_k + 1 == m_len) m_busy <= 1'b0;
    end else if (wb_cyc && wb_stb) begin
      m_busy  <= 1'b1;
      m_k     <= 0;
      m_abort <= 1'b0;
      m_base  <= wb_adr[23:2];
      m_rdat  <= {mem[{wb_adr[12:2], 1'b0}], mem[{wb_adr[12:2], 1'b1}]};
      m_wlo   <= (wb_sel == 4'b0011);
      m_wdat  <= (wb_sel == 4'b1100) ? wb_dat[31:16] : wb_dat[15:0];
      if (!wb_we) begin
        m_kind <= K_RD;  m_len <= 2 * RD_CYC + 2;
      end else if (WR_EN && (wb_sel == 4'b1100 || wb_sel == 4'b0011)) begin
        m_kind <= K_WR;  m_len <= WR_CYC + 3;
      end else begin
        m_kind <= K_ERR; m_len <= 1;
      end
    end
  end

  // Every-cycle comparison of the DUT against the model.
  logic                e_rstn, e_ce, e_oe, e_we, e_adv, e_dqoe, e_ack, e_err, c_adr, c_dq, c_dat, hi;
  logic [FLASH_AW-1:0] e_adr;
  always @(negedge clk) begin
    e_rstn = 1'b1; e_ce = 1'b1; e_oe = 1'b1; e_we = 1'b1; e_adv = 1'b1;
    e_dqoe = 1'b0; e_ack = 1'b0; e_err = 1'b0; c_adr = 1'b0; c_dq = 1'b0; c_dat = 1'b0;
    e_adr = '0; hi = 1'b0;
    if (rst || m_rst_left > 0) begin
      e_rstn = 1'b0;
    end else if (m_busy) begin
      if (m_kind == K_RD) begin
        hi = (m_k > RD_CYC) && (m_k <= 2 * RD_CYC);
        if (m_k < RD_CYC || hi) begin
          e_ce = 1'b0; e_oe = 1'b0; e_adv = 1'b0; c_adr = 1'b1; e_adr = {m_base, hi};
        end
        if (m_k == 2 * RD_CYC + 1 && !m_abort) begin e_ack = 1'b1; c_dat = 1'b1; end
      end else if (m_kind == K_WR) begin
        if (m_k <= WR_CYC + 1) begin
          e_ce = 1'b0; e_adv = 1'b0; e_dqoe = 1'b1; c_adr = 1'b1; c_dq = 1'b1; e_adr = {m_base, m_wlo};
        end
        if (m_k >= 1 && m_k <= WR_CYC) e_we = 1'b0;
        if (m_k == WR_CYC + 2 && !m_abort) e_ack = 1'b1;
      end else begin
        e_err = 1'b1;
      end
    end
    chk("rst_n",  32'(f_rst_n), 32'(e_rstn));
    chk("ce_n",   32'(f_ce_n),  32'(e_ce));
    chk("oe_n",   32'(f_oe_n),  32'(e_oe));
    chk("we_n",   32'(f_we_n),  32'(e_we));
    chk("adv_n",  32'(f_adv_n), 32'(e_adv));
    chk("dq_oe",  32'(f_dq_oe), 32'(e_dqoe));
    chk("ack",    32'(wb_ack),  32'(e_ack));
    chk("err",    32'(wb_err),  32'(e_err));
    chk("clk_o",  32'(f_clk),   32'd0);
    if (c_adr) chk("adr",  32'(f_adr),  32'(e_adr));
    if (c_dq)  chk("dq_o", 32'(f_dq_o), 32'(m_wdat));
    if (c_dat) chk("rdat", wb_dat_o, m_rdat);
  end

  // One WB transfer; called #1 after a rising edge. drop_at >= 0 abandons the
  // cycle after that many cycles; lat is the cycle index of the response.
  task automatic wb_xfer(input bit w, input logic [23:0] a, input logic [3:0] s, input logic [31:0] d,
                         input int drop_at, output int lat, output bit got_ack, output bit got_err);
    bit dropped = 1'b0;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = w; wb_adr = a; wb_sel = s; wb_dat = d;
    lat = -1; got_ack = 1'b0; got_err = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (wb_ack) got_ack = 1'b1;
      if (wb_err) got_err = 1'b1;
      if (got_ack || got_err) lat = n;
      @(posedge clk); #1;
      if (got_ack || got_err) break;
      if (drop_at >= 0 && n == drop_at) begin dropped = 1'b1; break; end
    end
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    if (!got_ack && !got_err && !dropped) chk("xfer_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_rst_rise();
    for (int n = 0; n < 200 && rise_cyc < 0; n++) @(posedge clk);
    #1;
  endtask

  int lat; bit ga, ge;
  logic [23:0] ra; logic [3:0] rs; int r, drop;

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
    mem[12'h100] = 16'h1234;
    mem[12'h101] = 16'hABCD;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rst_n", 32'(f_rst_n), 32'd0);
    chk("reset_ce_n",  32'(f_ce_n),  32'd1);
    chk("reset_adr",   32'(f_adr),   32'd0);
    chk("reset_dat",   wb_dat_o,     32'd0);
    chk("reset_dq_o",  32'(f_dq_o),  32'd0);

    // Release reset, request a read 10 cycles later; it waits for the hold.
    rst = 1'b0; rel_cyc = cyc_n; rise_cyc = -1;
    repeat (10) @(posedge clk); #1;
    wb_xfer(1'b0, 24'h000200, 4'hF, 32'h0, -1, lat, ga, ge);
    chk("rst_hold_cycles", 32'(rise_cyc), 32'd64);
    chk("first_rd_ack",    32'(ga),       32'd1);
    chk("first_rd_cycle",  32'(lat + 10), 32'd78);
    chk("first_rd_data",   wb_dat_o,      32'h1234ABCD);

    @(posedge clk); #1;
    wb_xfer(1'b0, 24'h000200, 4'hF, 32'h0, -1, lat, ga, ge);
    chk("idle_rd_latency", 32'(lat), 32'd14);

    // Half-word command write.
    we_low_cnt = 0;
    wb_xfer(1'b1, 24'h000400, 4'b1100, 32'h00FF0000, -1, lat, ga, ge);
`ifdef PFLASH_WRITE_EN
    chk("wr_ack",      32'(ga),         32'd1);
    chk("wr_latency",  32'(lat),        32'd7);
    chk("wr_pulse_len",32'(we_low_cnt), 32'd4);
    chk("wr_adr",      32'(pulse_adr),  32'h200);
    chk("wr_dq",       32'(pulse_dq),   32'h00FF);
`else
    chk("wr_err",      32'(ge),         32'd1);
    chk("wr_err_lat",  32'(lat),        32'd1);
    chk("wr_no_pulse", 32'(we_low_cnt), 32'd0);
`endif
    // Illegal byte-select: error, no write strobe.
    we_low_cnt = 0;
    wb_xfer(1'b1, 24'h000400, 4'b0101, 32'h12345678, -1, lat, ga, ge);
    chk("bad_sel_err",  32'(ge),         32'd1);
    chk("bad_sel_lat",  32'(lat),        32'd1);
    chk("bad_sel_no_we",32'(we_low_cnt), 32'd0);

    // Abandon a read during its high half; the next read must be correct.
    wb_xfer(1'b0, 24'h000200, 4'hF, 32'h0, 10, lat, ga, ge);
    chk("drop_no_ack", 32'(ga), 32'd0);
    wb_xfer(1'b0, 24'h000200, 4'hF, 32'h0, -1, lat, ga, ge);
    chk("after_drop_data", wb_dat_o, 32'h1234ABCD);

    // Asynchronous reset in the middle of a flash access.
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_adr = 24'h000400; wb_sel = 4'b1100; wb_dat = 32'h00FF0000;
    wb_we = WR_EN;
    repeat (3) @(posedge clk); #2;
    chk("pre_arst_ce_n", 32'(f_ce_n), 32'd0);
    rst = 1'b1; #1;
    chk("arst_ce_n",  32'(f_ce_n),  32'd1);
    chk("arst_oe_n",  32'(f_oe_n),  32'd1);
    chk("arst_we_n",  32'(f_we_n),  32'd1);
    chk("arst_dq_oe", 32'(f_dq_oe), 32'd0);
    chk("arst_rst_n", 32'(f_rst_n), 32'd0);
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    repeat (2) @(posedge clk); #1;
    rst = 1'b0; rel_cyc = cyc_n; rise_cyc = -1;
    wait_rst_rise();
    chk("arst_hold_cycles", 32'(rise_cyc), 32'd64);

    // Random traffic against the model.
    for (int t = 0; t < 150; t++) begin
      r  = int'($urandom_range(0, 8191));
      ra = 24'(r);
      r  = int'($urandom_range(0, 9));
      drop = (r == 0) ? int'($urandom_range(0, 12)) : -1;
      r  = int'($urandom_range(0, 9));
      if (r < 6) begin
        wb_xfer(1'b0, ra, 4'hF, 32'h0, drop, lat, ga, ge);
      end else begin
        rs = (r < 8) ? ((r == 6) ? 4'b1100 : 4'b0011) : 4'($urandom_range(0, 15));
        wb_xfer(1'b1, ra, rs, $urandom, drop, lat, ga, ge);
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    repeat (20) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1);
  end

endmodule
